// File: rtl/ones_acc_pkg.sv
// Shared types and constants for the ones frame accumulator.
//   state_e          : FSM state encoding (IDLE, ACCUM, HOLD)
//   SUM_W / IDX_W    : accumulator and frame index widths
//   MAX_NIBBLE_ONES  : largest legal ones count for one 4-bit nibble
//   DEF_FRAME_LEN    : default nibble counts per frame
//   DEF_THRESH       : default over-threshold compare value
package ones_acc_pkg;

  localparam int unsigned SUM_W           = 7;
  localparam int unsigned IDX_W           = 5;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned MAX_NIBBLE_ONES = 4;
  localparam int unsigned DEF_FRAME_LEN   = 8;
  localparam int unsigned DEF_THRESH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Limit an upstream count to the physically possible nibble maximum.
  function automatic logic [CNT_W-1:0] clamp_nibble(input logic [CNT_W-1:0] cnt);
    if (32'(cnt) > MAX_NIBBLE_ONES) begin
      return CNT_W'(MAX_NIBBLE_ONES);
    end
    return cnt;
  endfunction

endpackage : ones_acc_pkg

// File: rtl/ones_frame_accumulator.sv
// Sums FRAME_LEN per-nibble ones counts into a frame total and hands the
// result downstream with a valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a new frame (honoured in IDLE, or in HOLD on consume)
//   cnt_in       : nibble ones count, qualified by in_valid / in_ready
//   sum_out      : completed frame total, with over_thresh (sum >= THRESH)
//   sum_valid    : result held until sum_ready
//   busy         : FSM not idle
//   err          : sticky flag, an accepted count exceeded 4 in this frame
module ones_frame_accumulator
  import ones_acc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned THRESH    = DEF_THRESH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] cnt_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] sum_out,
  output logic       sum_valid,
  input  logic       sum_ready,
  output logic       over_thresh,
  output logic       busy,
  output logic       err
);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             over_q, over_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] cnt_clamped;
  logic [SUM_W-1:0] acc_next;

  assign cnt_clamped = clamp_nibble(cnt_in);
  assign acc_next    = acc_q + SUM_W'(cnt_clamped);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    over_d      = over_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end

      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          idx_d = idx_q + IDX_W'(1);
          if (32'(cnt_in) > MAX_NIBBLE_ONES) begin
            err_d = 1'b1;
          end
          // Last nibble: publish the total directly so it lands one cycle later.
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d     = ST_HOLD;
            sum_d       = acc_next;
            sum_valid_d = 1'b1;
            over_d      = (32'(acc_next) >= THRESH);
          end
        end
      end

      ST_HOLD: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          over_d      = 1'b0;
          if (start) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            idx_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake/status outputs follow the state being entered.
    in_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      over_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      over_q      <= over_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign sum_out     = sum_q;
  assign sum_valid   = sum_valid_q;
  assign over_thresh = over_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule : ones_frame_accumulator

// File: tb/tb_ones_frame_accumulator.sv
// Directed testbench for ones_frame_accumulator (FRAME_LEN=8, THRESH=16).
module tb_ones_frame_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] cnt_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] sum_out;
  logic       sum_valid;
  logic       sum_ready;
  logic       over_thresh;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  ones_frame_accumulator #(
    .FRAME_LEN(8),
    .THRESH   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cnt_in     (cnt_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .over_thresh(over_thresh),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Start a frame and feed eight back-to-back counts; vals[2:0] goes first.
  // Ends on the falling edge after the eighth transfer.
  task automatic run_frame(input string tag, input logic [23:0] vals);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      cnt_in   = vals[i*3 +: 3];
      @(negedge clk);
      if (i < 7) chk({tag, "_early_valid"}, 32'(sum_valid), 0);
    end
    in_valid = 1'b0;
    cnt_in   = 3'd0;
  endtask

  // Consume a held result with start low and confirm return to IDLE.
  task automatic consume(input string tag);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_valid"}, 32'(sum_valid), 0);
    chk({tag, "_idle_over"}, 32'(over_thresh), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cnt_in    = 3'd0;
    in_valid  = 1'b0;
    sum_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_sum_valid", 32'(sum_valid), 0);
    chk("rst_sum_out", 32'(sum_out), 0);
    chk("rst_over", 32'(over_thresh), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Full-scale frame: 8 x 4 = 32, result one cycle after last transfer
    run_frame("f4", {8{3'd4}});
    chk("f4_valid", 32'(sum_valid), 1);
    chk("f4_sum", 32'(sum_out), 32);
    chk("f4_over", 32'(over_thresh), 1);
    chk("f4_in_ready", 32'(in_ready), 0);
    chk("f4_busy", 32'(busy), 1);
    chk("f4_err", 32'(err), 0);

    // Backpressure: hold 5 more cycles, start ignored while sum_ready low
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_sum", 32'(sum_out), 32);
      chk("hold_valid", 32'(sum_valid), 1);
      chk("hold_over", 32'(over_thresh), 1);
    end
    // Consume with start high: straight into a fresh ACCUM
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    start     = 1'b0;
    chk("restart_valid", 32'(sum_valid), 0);
    chk("restart_in_ready", 32'(in_ready), 1);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_over", 32'(over_thresh), 0);

    // Gapped frame: cnt 1 on even cycles only, 8 accepted -> sum 8
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      cnt_in   = 3'd1;
      @(negedge clk);
      if (i < 14) chk("gap_early_valid", 32'(sum_valid), 0);
    end
    in_valid = 1'b0;
    chk("gap_valid", 32'(sum_valid), 1);
    chk("gap_sum", 32'(sum_out), 8);
    chk("gap_over", 32'(over_thresh), 0);
    consume("gap");

    // Threshold boundary: 15 below, 16 at threshold
    run_frame("t15", {3'd1, {7{3'd2}}});
    chk("t15_sum", 32'(sum_out), 15);
    chk("t15_over", 32'(over_thresh), 0);
    consume("t15");
    run_frame("t16", {8{3'd2}});
    chk("t16_sum", 32'(sum_out), 16);
    chk("t16_over", 32'(over_thresh), 1);
    consume("t16");

    // Out-of-range count clamps to 4 and sets sticky err
    run_frame("clamp", {{6{3'd0}}, 3'd7, 3'd3});
    chk("clamp_valid", 32'(sum_valid), 1);
    chk("clamp_sum", 32'(sum_out), 7);
    chk("clamp_err", 32'(err), 1);
    chk("clamp_over", 32'(over_thresh), 0);
    sum_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    start     = 1'b0;
    chk("clamp_err_cleared", 32'(err), 0);
    chk("clamp_next_in_ready", 32'(in_ready), 1);

    // Reset mid-frame after 3 transfers of 2, asserted between edges
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      cnt_in   = 3'd2;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_in_ready", 32'(in_ready), 0);
    chk("async_valid", 32'(sum_valid), 0);
    chk("async_sum", 32'(sum_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_valid", 32'(sum_valid), 0);
    run_frame("zero", {8{3'd0}});
    chk("zero_valid", 32'(sum_valid), 1);
    chk("zero_sum", 32'(sum_out), 0);
    chk("zero_over", 32'(over_thresh), 0);
    chk("zero_err", 32'(err), 0);
    consume("zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ones_frame_accumulator
